// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MD op codes and FSM states.
package mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/mdu_div.sv
// Combinational signed/unsigned divider producing quotient and remainder,
// including the divide-by-zero and signed-overflow results.
module mdu_div #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         is_signed,
   output logic [W-1:0] quo,
   output logic [W-1:0] rem
);

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   logic         a_neg;
   logic         b_neg;
   logic [W-1:0] a_abs;
   logic [W-1:0] b_abs;
   logic [W-1:0] uq;
   logic [W-1:0] ur;

   assign a_neg = is_signed & a[W-1];
   assign b_neg = is_signed & b[W-1];
   assign a_abs = a_neg ? (~a + 1'b1) : a;
   assign b_abs = b_neg ? (~b + 1'b1) : b;
   assign uq    = (b_abs == '0) ? '1 : (a_abs / b_abs);
   assign ur    = (b_abs == '0) ? a_abs : (a_abs % b_abs);

   // Quotient sign follows the operand signs, remainder sign follows the dividend.
   always_comb begin
      quo = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
      rem = a_neg ? (~ur + 1'b1) : ur;
      if (b == '0) begin
         quo = '1;
         rem = a;
      end else if (is_signed && (a == MOST_NEG) && (b == '1)) begin
         quo = a;
         rem = '0;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency MULT/DIV with HI/LO registers,
// MTHI/MTLO writes and a stall request for the hazard unit.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int DATAWIDTH   = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [DATAWIDTH-1:0] rs_data,
   input  logic [DATAWIDTH-1:0] rt_data,
   input  logic                 rd_sel,
   output logic [DATAWIDTH-1:0] rd_data,
   output logic                 busy,
   input  logic                 md_in_d,
   output logic                 stall
);

   localparam int W = DATAWIDTH;
   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   md_state_e      state;
   logic [3:0]     cnt;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;
   logic [W-1:0]   pend_hi;
   logic [W-1:0]   pend_lo;
   logic [2*W-1:0] mul_a;
   logic [2*W-1:0] mul_b;
   logic [2*W-1:0] prod;
   logic [W-1:0]   div_q;
   logic [W-1:0]   div_r;

   // Sign-extend for MULT so the low 2W bits of the unsigned product are the signed product.
   assign mul_a = (op == MD_MULT) ? {{W{rs_data[W-1]}}, rs_data} : {{W{1'b0}}, rs_data};
   assign mul_b = (op == MD_MULT) ? {{W{rt_data[W-1]}}, rt_data} : {{W{1'b0}}, rt_data};
   assign prod  = mul_a * mul_b;

   mdu_div #(.W(W)) u_div (
      .a         (rs_data),
      .b         (rt_data),
      .is_signed (op == MD_DIV),
      .quo       (div_q),
      .rem       (div_r)
   );

   // start is a single-cycle request honoured only in IDLE; while busy it is dropped, never queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         busy    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  case (op)
                     MD_MULT, MD_MULTU: begin
                        pend_hi <= prod[2*W-1:W];
                        pend_lo <= prod[W-1:0];
                        cnt     <= MULT_LOAD;
                        state   <= ST_BUSY;
                        busy    <= 1'b1;
                     end
                     MD_DIV, MD_DIVU: begin
                        pend_hi <= div_r;
                        pend_lo <= div_q;
                        cnt     <= DIV_LOAD;
                        state   <= ST_BUSY;
                        busy    <= 1'b1;
                     end
                     MD_MTHI: hi <= rs_data;
                     MD_MTLO: lo <= rs_data;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  hi    <= pend_hi;
                  lo    <= pend_lo;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data = rd_sel ? hi : lo;
   assign stall   = md_in_d & (busy | (start & (op <= MD_DIVU)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised self-checking bench for mdu_ctrl against an arithmetic HI/LO model.
module tb_mdu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rd_sel;
   logic [31:0] rd_data;
   logic        busy;
   logic        md_in_d;
   logic        stall;

   int total;
   int bad;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mdu_ctrl #(.DATAWIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .rd_sel  (rd_sel),
      .rd_data (rd_data),
      .busy    (busy),
      .md_in_d (md_in_d),
      .stall   (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain 64-bit / int arithmetic with the architectural special cases.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
      longint          ps;
      longint unsigned pu;
      int              ia;
      int              ib;
      ia = a;
      ib = b;
      case (o)
         3'd0: begin ps = longint'(ia) * longint'(ib); h = ps[63:32]; l = ps[31:0]; end
         3'd1: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
         3'd2: begin
            if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = 32'd0; end
            else begin l = ia / ib; h = ia % ib; end
         end
         3'd3: begin
            if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
            else begin l = a / b; h = a % b; end
         end
         3'd4: h = a;
         3'd5: l = a;
         default: ;
      endcase
   endfunction

   function automatic int exp_cycles(input logic [2:0] o);
      if (o <= 3'd1) return 5;
      if (o <= 3'd3) return 10;
      return 0;
   endfunction

   // Issues one op from just after a falling edge; returns busy length and final HI/LO.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic [31:0] h, output logic [31:0] l);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
      rd_sel = 1'b1; #1; h = rd_data;
      rd_sel = 1'b0; #1; l = rd_data;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
      rd_sel = 1'b0; md_in_d = 1'b1;
      hi_m = '0; lo_m = '0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", rd_data); end
      rd_sel = 1'b1; #1;
      total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", rd_data); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      md_in_d = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mult();
      int cyc; logic [31:0] h; logic [31:0] l;
      // Issued on the very first edge after reset release.
      do_op(3'd0, 32'hFFFF_FFFE, 32'd3, cyc, h, l);
      model(3'd0, 32'hFFFF_FFFE, 32'd3, hi_m, lo_m);
      total++; if (cyc != 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", cyc); end
      total++; if (h !== 32'hFFFF_FFFF || h !== hi_m) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", h); end
      total++; if (l !== 32'hFFFF_FFFA || l !== lo_m) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", l); end
      do_op(3'd1, 32'hFFFF_FFFE, 32'd3, cyc, h, l);
      model(3'd1, 32'hFFFF_FFFE, 32'd3, hi_m, lo_m);
      total++; if (h !== 32'h0000_0002 || l !== 32'hFFFF_FFFA) begin
         bad++; $display("FAIL multu got hi=%h lo=%h exp hi=00000002 lo=fffffffa", h, l);
      end
   endtask

   task automatic test_div();
      int cyc; logic [31:0] h; logic [31:0] l;
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc, h, l);
      model(3'd2, 32'hFFFF_FFF9, 32'd2, hi_m, lo_m);
      total++; if (cyc != 10) begin bad++; $display("FAIL div_busy got=%0d exp=10", cyc); end
      total++; if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL div_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", h, l);
      end
      do_op(3'd3, 32'd7, 32'd0, cyc, h, l);
      model(3'd3, 32'd7, 32'd0, hi_m, lo_m);
      total++; if (l !== 32'hFFFF_FFFF || h !== 32'd7) begin
         bad++; $display("FAIL divu_zero got hi=%h lo=%h exp hi=00000007 lo=ffffffff", h, l);
      end
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, h, l);
      model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, hi_m, lo_m);
      total++; if (l !== 32'h8000_0000 || h !== 32'd0) begin
         bad++; $display("FAIL div_ovf got hi=%h lo=%h exp hi=00000000 lo=80000000", h, l);
      end
      do_op(3'd2, 32'hFFFF_FFF6, 32'd0, cyc, h, l);
      model(3'd2, 32'hFFFF_FFF6, 32'd0, hi_m, lo_m);
      total++; if (l !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFF6) begin
         bad++; $display("FAIL div_zero got hi=%h lo=%h exp hi=fffffff6 lo=ffffffff", h, l);
      end
   endtask

   task automatic test_ignore_busy();
      int cyc; logic [31:0] old_lo; logic [31:0] a; logic [31:0] b;
      a = $urandom; b = $urandom;
      old_lo = lo_m;
      model(3'd0, a, b, hi_m, lo_m);
      start = 1'b1; op = 3'd0; rs_data = a; rt_data = b; md_in_d = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      @(negedge clk);
      cyc = 2;
      start = 1'b1; op = 3'd5; rs_data = 32'h55; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL busy_stall got=%b exp=1", stall); end
      rd_sel = 1'b0;
      total++; if (rd_data !== old_lo) begin bad++; $display("FAIL pending_hidden got=%h exp=%h", rd_data, old_lo); end
      @(negedge clk);
      start = 1'b0;
      while (busy === 1'b1 && cyc < 40) begin
         if (stall !== 1'b1) begin total++; bad++; $display("FAIL busy_stall_loop cyc=%0d got=%b exp=1", cyc, stall); end
         cyc++;
         @(negedge clk);
      end
      total++; if (cyc != 5) begin bad++; $display("FAIL ignore_busy_len got=%0d exp=5", cyc); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b exp=0", stall); end
      rd_sel = 1'b0; #1;
      total++; if (rd_data !== lo_m) begin bad++; $display("FAIL ignore_mtlo_lo got=%h exp=%h", rd_data, lo_m); end
      rd_sel = 1'b1; #1;
      total++; if (rd_data !== hi_m) begin bad++; $display("FAIL ignore_mtlo_hi got=%h exp=%h", rd_data, hi_m); end
      // Stall is combinational on an IDLE start: MULT/DIV stall, MTHI does not.
      op = 3'd2; start = 1'b1; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL start_stall got=%b exp=1", stall); end
      op = 3'd4; #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL mt_stall got=%b exp=0", stall); end
      start = 1'b0; md_in_d = 1'b0;
   endtask

   task automatic test_reset_abort();
      int cyc; logic [31:0] h; logic [31:0] l;
      start = 1'b1; op = 3'd2; rs_data = 32'd1000; rt_data = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0; #1;
      hi_m = '0; lo_m = '0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      rd_sel = 1'b1; #1;
      total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL abort_hi got=%h exp=0", rd_data); end
      rd_sel = 1'b0; #1;
      total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL abort_lo got=%h exp=0", rd_data); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      total++; if (busy !== 1'b0 || rd_data !== 32'd0) begin
         bad++; $display("FAIL abort_no_commit got busy=%b lo=%h exp busy=0 lo=0", busy, rd_data);
      end
      do_op(3'd4, 32'h1234, 32'd0, cyc, h, l);
      model(3'd4, 32'h1234, 32'd0, hi_m, lo_m);
      total++; if (h !== 32'h1234 || l !== 32'd0 || cyc != 0) begin
         bad++; $display("FAIL abort_mthi got hi=%h lo=%h cyc=%0d exp hi=00001234 lo=0 cyc=0", h, l, cyc);
      end
   endtask

   task automatic test_random();
      int cyc; logic [31:0] h; logic [31:0] l; logic [2:0] o; logic [31:0] a; logic [31:0] b;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         do_op(o, a, b, cyc, h, l);
         model(o, a, b, hi_m, lo_m);
         total++;
         if (cyc != exp_cycles(o) || h !== hi_m || l !== lo_m) begin
            bad++;
            $display("FAIL rand op=%0d a=%h b=%h got cyc=%0d hi=%h lo=%h exp cyc=%0d hi=%h lo=%h",
                     o, a, b, cyc, h, l, exp_cycles(o), hi_m, lo_m);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc; logic [31:0] h; logic [31:0] l;
      do_op(3'd5, 32'hA5A5_0001, 32'd0, cyc, h, l);
      model(3'd5, 32'hA5A5_0001, 32'd0, hi_m, lo_m);
      do_op(3'd4, 32'h5A5A_0002, 32'd0, cyc, h, l);
      model(3'd4, 32'h5A5A_0002, 32'd0, hi_m, lo_m);
      total++; if (h !== hi_m || l !== lo_m) begin
         bad++; $display("FAIL mt_pair got hi=%h lo=%h exp hi=%h lo=%h", h, l, hi_m, lo_m);
      end
      do_op(3'd7, 32'hDEAD_BEEF, 32'd1, cyc, h, l);
      total++; if (h !== hi_m || l !== lo_m || cyc != 0) begin
         bad++; $display("FAIL noop got hi=%h lo=%h cyc=%0d exp hi=%h lo=%h cyc=0", h, l, cyc, hi_m, lo_m);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_mult();
      test_div();
      test_ignore_busy();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
